// File: rtl/vx_tl_lane_adapter_if.sv
// rtl/vx_tl_lane_adapter_if.sv - Core dcache request/response and per-lane TileLink-UL A/D signal bundle
// The slave modport is the adapter's view; master is the surrounding core plus TL fabric.
interface vx_tl_lane_adapter_if #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH  = 10
);
  logic [NUM_LANES-1:0]            core_req_valid;
  logic [NUM_LANES-1:0]            core_req_rw;
  logic [NUM_LANES-1:0]            core_req_ready;
  logic [4*NUM_LANES-1:0]          core_req_byteen;
  logic [ADDR_WIDTH*NUM_LANES-1:0] core_req_addr;
  logic [32*NUM_LANES-1:0]         core_req_data;
  logic [TAG_WIDTH*NUM_LANES-1:0]  core_req_tag;

  logic                            core_rsp_valid;
  logic [NUM_LANES-1:0]            core_rsp_tmask;
  logic [32*NUM_LANES-1:0]         core_rsp_data;
  logic [TAG_WIDTH-1:0]            core_rsp_tag;
  logic                            core_rsp_ready;

  logic [NUM_LANES-1:0]            a_valid;
  logic [NUM_LANES-1:0]            a_ready;
  logic [3*NUM_LANES-1:0]          a_opcode;
  logic [3*NUM_LANES-1:0]          a_param;
  logic [4*NUM_LANES-1:0]          a_size;
  logic [NUM_LANES-1:0]            a_corrupt;
  logic [TAG_WIDTH*NUM_LANES-1:0]  a_source;
  logic [32*NUM_LANES-1:0]         a_address;
  logic [4*NUM_LANES-1:0]          a_mask;
  logic [32*NUM_LANES-1:0]         a_data;

  logic [NUM_LANES-1:0]            d_valid;
  logic [NUM_LANES-1:0]            d_ready;
  logic [3*NUM_LANES-1:0]          d_opcode;
  logic [TAG_WIDTH*NUM_LANES-1:0]  d_source;
  logic [32*NUM_LANES-1:0]         d_data;

  modport slave (
    input  core_req_valid, core_req_rw, core_req_byteen, core_req_addr, core_req_data, core_req_tag,
    output core_req_ready,
    output core_rsp_valid, core_rsp_tmask, core_rsp_data, core_rsp_tag,
    input  core_rsp_ready,
    output a_valid, a_opcode, a_param, a_size, a_corrupt, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_source, d_data,
    output d_ready
  );

  modport master (
    output core_req_valid, core_req_rw, core_req_byteen, core_req_addr, core_req_data, core_req_tag,
    input  core_req_ready,
    input  core_rsp_valid, core_rsp_tmask, core_rsp_data, core_rsp_tag,
    output core_rsp_ready,
    input  a_valid, a_opcode, a_param, a_size, a_corrupt, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_source, d_data,
    input  d_ready
  );
endinterface

// File: rtl/vx_tl_lane_adapter.sv
// rtl/vx_tl_lane_adapter.sv - Per-lane Vortex dcache to TileLink-UL bridge with tag-coalesced responses
// Optional perf counters are built when VX_TL_ADAPTER_PERF_EN is defined.
module vx_tl_lane_adapter #(
  parameter int NUM_LANES       = 4,
  parameter int ADDR_WIDTH      = 30,
  parameter int TAG_WIDTH       = 10,
  parameter int RSP_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  vx_tl_lane_adapter_if.slave  bus,
  output logic                 busy,
  output logic [31:0]          perf_req_count,
  output logic [31:0]          perf_stall_count
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          data;
  } rsp_entry_t;

  logic [NUM_LANES-1:0]                 abuf_valid_q, abuf_valid_d;
  logic [NUM_LANES-1:0][2:0]            abuf_opcode_q, abuf_opcode_d;
  logic [NUM_LANES-1:0][31:0]           abuf_addr_q, abuf_addr_d;
  logic [NUM_LANES-1:0][3:0]            abuf_mask_q, abuf_mask_d;
  logic [NUM_LANES-1:0][31:0]           abuf_data_q, abuf_data_d;
  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]  abuf_source_q, abuf_source_d;
  logic [NUM_LANES-1:0][CW-1:0]         outstanding_q, outstanding_d;
  logic [NUM_LANES-1:0][PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  rsp_entry_t [NUM_LANES-1:0][RSP_DEPTH-1:0] fifo_mem_q, fifo_mem_d;

  logic [NUM_LANES-1:0] req_ready, req_fire, d_fire, fifo_empty, fifo_full, tmask;
  rsp_entry_t [NUM_LANES-1:0] head;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic rsp_fire;

  always_comb begin
    abuf_valid_d  = abuf_valid_q;
    abuf_opcode_d = abuf_opcode_q;
    abuf_addr_d   = abuf_addr_q;
    abuf_mask_d   = abuf_mask_q;
    abuf_data_d   = abuf_data_q;
    abuf_source_d = abuf_source_q;
    outstanding_d = outstanding_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_mem_d    = fifo_mem_q;
    fifo_empty    = '0;
    fifo_full     = '0;
    head          = '0;
    tmask         = '0;
    req_ready     = '0;
    req_fire      = '0;
    d_fire        = '0;
    sel_tag       = '0;

    // Descending scan leaves the lowest-indexed non-empty head tag in sel_tag.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][PW] != rd_ptr_q[i][PW]) &&
                      (wr_ptr_q[i][PW-1:0] == rd_ptr_q[i][PW-1:0]);
      head[i]       = fifo_mem_q[i][rd_ptr_q[i][PW-1:0]];
      if (!fifo_empty[i]) sel_tag = head[i].tag;
    end
    rsp_fire = ~&fifo_empty & bus.core_rsp_ready;

    for (int i = 0; i < NUM_LANES; i++) begin
      tmask[i]     = ~fifo_empty[i] & (head[i].tag == sel_tag);
      req_ready[i] = (~abuf_valid_q[i] | bus.a_ready[i]) &
                     (outstanding_q[i] < CW'(MAX_OUTSTANDING));
      req_fire[i]  = bus.core_req_valid[i] & req_ready[i];
      d_fire[i]    = bus.d_valid[i] & ~fifo_full[i];

      if (bus.a_ready[i]) abuf_valid_d[i] = 1'b0;
      if (req_fire[i]) begin
        abuf_valid_d[i]  = 1'b1;
        abuf_opcode_d[i] = ~bus.core_req_rw[i] ? OP_GET :
                           (&bus.core_req_byteen[i*4 +: 4]) ? OP_PUT_FULL : OP_PUT_PARTIAL;
        abuf_addr_d[i]   = 32'({bus.core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH], 2'b00});
        abuf_mask_d[i]   = bus.core_req_byteen[i*4 +: 4];
        abuf_data_d[i]   = bus.core_req_data[i*32 +: 32];
        abuf_source_d[i] = bus.core_req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end

      // A stray D beat at zero count is dropped from the counter rather than wrapping it.
      if (req_fire[i] && !d_fire[i]) begin
        outstanding_d[i] = outstanding_q[i] + 1'b1;
      end else if (!req_fire[i] && d_fire[i] && outstanding_q[i] != '0) begin
        outstanding_d[i] = outstanding_q[i] - 1'b1;
      end

      if (d_fire[i] && bus.d_opcode[i*3 +: 3] == OP_ACK_DATA) begin
        fifo_mem_d[i][wr_ptr_q[i][PW-1:0]] = {bus.d_source[i*TAG_WIDTH +: TAG_WIDTH],
                                              bus.d_data[i*32 +: 32]};
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      end
      if (rsp_fire && tmask[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      abuf_valid_q  <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      abuf_valid_q  <= abuf_valid_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
    abuf_opcode_q <= abuf_opcode_d;
    abuf_addr_q   <= abuf_addr_d;
    abuf_mask_q   <= abuf_mask_d;
    abuf_data_q   <= abuf_data_d;
    abuf_source_q <= abuf_source_d;
    fifo_mem_q    <= fifo_mem_d;
  end

  assign bus.core_req_ready = req_ready;
  assign bus.a_valid        = abuf_valid_q;
  assign bus.a_opcode       = abuf_opcode_q;
  assign bus.a_param        = '0;
  assign bus.a_size         = {NUM_LANES{4'd2}};
  assign bus.a_corrupt      = '0;
  assign bus.a_source       = abuf_source_q;
  assign bus.a_address      = abuf_addr_q;
  assign bus.a_mask         = abuf_mask_q;
  assign bus.a_data         = abuf_data_q;
  assign bus.d_ready        = ~fifo_full;
  assign bus.core_rsp_valid = ~&fifo_empty;
  assign bus.core_rsp_tmask = tmask;
  assign bus.core_rsp_tag   = sel_tag;
  assign busy               = (|abuf_valid_q) | (|outstanding_q) | ~&fifo_empty;

  always_comb begin
    bus.core_rsp_data = '0;
    for (int i = 0; i < NUM_LANES; i++) bus.core_rsp_data[i*32 +: 32] = head[i].data;
  end

`ifdef VX_TL_ADAPTER_PERF_EN
  logic [31:0] perf_req_count_q, perf_req_count_d;
  logic [31:0] perf_stall_count_q, perf_stall_count_d;

  always_comb begin
    perf_req_count_d = perf_req_count_q;
    for (int i = 0; i < NUM_LANES; i++) perf_req_count_d = perf_req_count_d + 32'(req_fire[i]);
    perf_stall_count_d = perf_stall_count_q + 32'(|(bus.core_req_valid & ~req_ready));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_req_count_q   <= '0;
      perf_stall_count_q <= '0;
    end else begin
      perf_req_count_q   <= perf_req_count_d;
      perf_stall_count_q <= perf_stall_count_d;
    end
  end

  assign perf_req_count   = perf_req_count_q;
  assign perf_stall_count = perf_stall_count_q;
`else
  assign perf_req_count   = '0;
  assign perf_stall_count = '0;
`endif
endmodule

// File: tb/tb_vx_tl_lane_adapter.sv
// tb/tb_vx_tl_lane_adapter.sv - Directed and randomized checks of vx_tl_lane_adapter against a queue model
module tb_vx_tl_lane_adapter;
  localparam int NL = 4, AW = 30, TW = 10, DEPTH = 4, MAXO = 8;
  localparam logic [2:0] OP_GET = 3'd4;
`ifdef VX_TL_ADAPTER_PERF_EN
  localparam int EXP_PERF_REQ = 10, EXP_PERF_STALL = 3;
`else
  localparam int EXP_PERF_REQ = 0, EXP_PERF_STALL = 0;
`endif

  typedef struct packed {
    logic [2:0]    op;
    logic [31:0]   addr;
    logic [3:0]    mask;
    logic [31:0]   data;
    logic [TW-1:0] src;
  } abeat_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } rsp_t;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  logic [31:0] perf_req_count, perf_stall_count;
  int errors = 0;
  int checks = 0;

  abeat_t m_abuf[NL][$];
  abeat_t m_slave[NL][$];
  rsp_t   m_rsp[NL][$];
  int     m_out[NL];

  always #5 clock = ~clock;

  vx_tl_lane_adapter_if #(.NUM_LANES(NL), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  vx_tl_lane_adapter #(
    .NUM_LANES(NL), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .RSP_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .perf_req_count(perf_req_count),
    .perf_stall_count(perf_stall_count)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.core_req_valid  = '0;
    bus.core_req_rw     = '0;
    bus.core_req_byteen = '0;
    bus.core_req_addr   = '0;
    bus.core_req_data   = '0;
    bus.core_req_tag    = '0;
    bus.core_rsp_ready  = 1'b1;
    bus.a_ready         = '1;
    bus.d_valid         = '0;
    bus.d_opcode        = '0;
    bus.d_source        = '0;
    bus.d_data          = '0;
  endtask

  task automatic drive_req(input int lane, input logic rw, input logic [3:0] be,
                           input logic [AW-1:0] addr, input logic [31:0] data, input logic [TW-1:0] tag);
    bus.core_req_valid[lane]         = 1'b1;
    bus.core_req_rw[lane]            = rw;
    bus.core_req_byteen[lane*4 +: 4] = be;
    bus.core_req_addr[lane*AW +: AW] = addr;
    bus.core_req_data[lane*32 +: 32] = data;
    bus.core_req_tag[lane*TW +: TW]  = tag;
  endtask

  task automatic drive_d(input int lane, input logic [2:0] op, input logic [TW-1:0] src, input logic [31:0] data);
    bus.d_valid[lane]           = 1'b1;
    bus.d_opcode[lane*3 +: 3]   = op;
    bus.d_source[lane*TW +: TW] = src;
    bus.d_data[lane*32 +: 32]   = data;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic abeat_t obs_beat(input int i);
    return '{op: bus.a_opcode[i*3 +: 3], addr: bus.a_address[i*32 +: 32], mask: bus.a_mask[i*4 +: 4],
             data: bus.a_data[i*32 +: 32], src: bus.a_source[i*TW +: TW]};
  endfunction

  // One randomized cycle: the bench acts as core and TL slave, checks outputs, then advances the model.
  task automatic rand_cycle(input bit allow_req);
    logic [NL-1:0] e_ready, e_avalid, e_dready, e_tmask;
    abeat_t new_beat[NL];
    abeat_t b;
    int sel;
    for (int i = 0; i < NL; i++) begin
      bus.core_req_valid[i]         = allow_req && ($urandom_range(0, 1) == 1);
      bus.core_req_rw[i]            = ($urandom_range(0, 3) == 0);
      bus.core_req_byteen[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      bus.core_req_addr[i*AW +: AW] = AW'($urandom);
      bus.core_req_data[i*32 +: 32] = $urandom;
      bus.core_req_tag[i*TW +: TW]  = TW'($urandom_range(0, 3));
      bus.a_ready[i]                = ($urandom_range(0, 3) != 0);
      bus.d_valid[i]                = 1'b0;
      bus.d_opcode[i*3 +: 3]        = 3'd0;
      bus.d_source[i*TW +: TW]      = '0;
      bus.d_data[i*32 +: 32]        = $urandom;
      if (m_slave[i].size() != 0) begin
        bus.d_valid[i]              = ($urandom_range(0, 2) != 0);
        bus.d_opcode[i*3 +: 3]      = (m_slave[i][0].op == OP_GET) ? 3'd1 : 3'd0;
        bus.d_source[i*TW +: TW]    = m_slave[i][0].src;
      end
    end
    bus.core_rsp_ready = ($urandom_range(0, 3) != 0);
    #1;
    sel = -1;
    for (int i = 0; i < NL; i++) begin
      e_ready[i]  = (m_abuf[i].size() == 0 || bus.a_ready[i]) && (m_out[i] < MAXO);
      e_avalid[i] = (m_abuf[i].size() != 0);
      e_dready[i] = (m_rsp[i].size() < DEPTH);
      if (sel < 0 && m_rsp[i].size() != 0) sel = i;
      new_beat[i].op   = !bus.core_req_rw[i] ? OP_GET : (bus.core_req_byteen[i*4 +: 4] == 4'hF) ? 3'd0 : 3'd1;
      new_beat[i].addr = {bus.core_req_addr[i*AW +: AW], 2'b00};
      new_beat[i].mask = bus.core_req_byteen[i*4 +: 4];
      new_beat[i].data = bus.core_req_data[i*32 +: 32];
      new_beat[i].src  = bus.core_req_tag[i*TW +: TW];
    end
    e_tmask = '0;
    if (sel >= 0) begin
      for (int i = 0; i < NL; i++)
        e_tmask[i] = (m_rsp[i].size() != 0) && (m_rsp[i][0].tag == m_rsp[sel][0].tag);
    end
    check_eq("rnd_req_ready", 128'(bus.core_req_ready), 128'(e_ready));
    check_eq("rnd_a_valid", 128'(bus.a_valid), 128'(e_avalid));
    check_eq("rnd_d_ready", 128'(bus.d_ready), 128'(e_dready));
    check_eq("rnd_rsp_valid", 128'(bus.core_rsp_valid), 128'(sel >= 0));
    for (int i = 0; i < NL; i++)
      if (e_avalid[i]) check_eq($sformatf("rnd_a_beat%0d", i), 128'(obs_beat(i)), 128'(m_abuf[i][0]));
    if (sel >= 0) begin
      check_eq("rnd_rsp_tmask", 128'(bus.core_rsp_tmask), 128'(e_tmask));
      check_eq("rnd_rsp_tag", 128'(bus.core_rsp_tag), 128'(m_rsp[sel][0].tag));
      for (int i = 0; i < NL; i++)
        if (e_tmask[i]) check_eq($sformatf("rnd_rsp_data%0d", i), 128'(bus.core_rsp_data[i*32 +: 32]),
                                 128'(m_rsp[i][0].data));
    end
    @(posedge clock);
    if (sel >= 0 && bus.core_rsp_ready) begin
      for (int i = 0; i < NL; i++) if (e_tmask[i]) void'(m_rsp[i].pop_front());
    end
    for (int i = 0; i < NL; i++) begin
      if (e_avalid[i] && bus.a_ready[i]) m_slave[i].push_back(m_abuf[i].pop_front());
      if (bus.core_req_valid[i] && e_ready[i]) begin
        m_abuf[i].push_back(new_beat[i]);
        m_out[i]++;
      end
      if (bus.d_valid[i] && e_dready[i]) begin
        b = m_slave[i].pop_front();
        if (m_out[i] > 0) m_out[i]--;
        if (b.op == OP_GET) m_rsp[i].push_back('{tag: b.src, data: bus.d_data[i*32 +: 32]});
      end
    end
    #1;
  endtask

  initial begin
    do_reset();
    check_eq("rst_a_valid", 128'(bus.a_valid), 128'(0));
    check_eq("rst_rsp_valid", 128'(bus.core_rsp_valid), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_d_ready", 128'(bus.d_ready), 128'(4'hF));
    check_eq("rst_req_ready", 128'(bus.core_req_ready), 128'(4'hF));
    check_eq("rst_perf_req", 128'(perf_req_count), 128'(0));

    // Single load on lane 0
    drive_req(0, 1'b0, 4'hF, 30'h100, 32'h0, 10'h2A);
    step();
    clear_inputs();
    check_eq("ld_a_valid", 128'(bus.a_valid), 128'(4'b0001));
    check_eq("ld_a_address", 128'(bus.a_address[31:0]), 128'(32'h400));
    check_eq("ld_a_opcode", 128'(bus.a_opcode[2:0]), 128'(3'd4));
    check_eq("ld_a_size", 128'(bus.a_size[3:0]), 128'(4'd2));
    check_eq("ld_a_param_corrupt", 128'({bus.a_param[2:0], bus.a_corrupt[0]}), 128'(0));
    check_eq("ld_a_source", 128'(bus.a_source[TW-1:0]), 128'(10'h2A));
    step();
    check_eq("ld_a_drained", 128'(bus.a_valid), 128'(0));
    drive_d(0, 3'd1, 10'h2A, 32'hDEADBEEF);
    check_eq("ld_rsp_before", 128'(bus.core_rsp_valid), 128'(0));
    step();
    clear_inputs();
    check_eq("ld_rsp_valid", 128'(bus.core_rsp_valid), 128'(1));
    check_eq("ld_rsp_tmask", 128'(bus.core_rsp_tmask), 128'(4'b0001));
    check_eq("ld_rsp_tag", 128'(bus.core_rsp_tag), 128'(10'h2A));
    check_eq("ld_rsp_data", 128'(bus.core_rsp_data[31:0]), 128'(32'hDEADBEEF));
    step();
    check_eq("ld_rsp_popped", 128'(bus.core_rsp_valid), 128'(0));
    check_eq("ld_busy_idle", 128'(busy), 128'(0));

    // Split-arrival coalesce of tag 5
    for (int l = 0; l < NL; l++) drive_req(l, 1'b0, 4'hF, AW'(32'h200 + l), 32'h0, 10'd5);
    step();
    clear_inputs();
    step();
    drive_d(2, 3'd1, 10'd5, 32'hA2A2_0002);
    drive_d(3, 3'd1, 10'd5, 32'hA3A3_0003);
    step();
    clear_inputs();
    check_eq("co_first_tmask", 128'(bus.core_rsp_tmask), 128'(4'b1100));
    check_eq("co_first_tag", 128'({bus.core_rsp_valid, bus.core_rsp_tag}), 128'({1'b1, 10'd5}));
    check_eq("co_first_data", 128'(bus.core_rsp_data[127:64]), 128'({32'hA3A3_0003, 32'hA2A2_0002}));
    step();
    check_eq("co_gap_valid", 128'(bus.core_rsp_valid), 128'(0));
    step();
    drive_d(0, 3'd1, 10'd5, 32'hA0A0_0000);
    drive_d(1, 3'd1, 10'd5, 32'hA1A1_0001);
    step();
    clear_inputs();
    check_eq("co_second_tmask", 128'(bus.core_rsp_tmask), 128'(4'b0011));
    check_eq("co_second_tag", 128'({bus.core_rsp_valid, bus.core_rsp_tag}), 128'({1'b1, 10'd5}));
    check_eq("co_second_data", 128'(bus.core_rsp_data[63:0]), 128'({32'hA1A1_0001, 32'hA0A0_0000}));
    step();
    check_eq("co_busy_idle", 128'(busy), 128'(0));

    // Stores on lane 1: partial then full
    drive_req(1, 1'b1, 4'b0011, 30'h40, 32'h1234_5678, 10'd7);
    step();
    clear_inputs();
    check_eq("st_partial_op", 128'(bus.a_opcode[5:3]), 128'(3'd1));
    check_eq("st_partial_mask", 128'(bus.a_mask[7:4]), 128'(4'b0011));
    step();
    drive_req(1, 1'b1, 4'hF, 30'h41, 32'h9ABC_DEF0, 10'd8);
    step();
    clear_inputs();
    check_eq("st_full_op", 128'(bus.a_opcode[5:3]), 128'(3'd0));
    check_eq("st_full_data", 128'(bus.a_data[63:32]), 128'(32'h9ABC_DEF0));
    step();
    drive_d(1, 3'd0, 10'd7, 32'h0);
    step();
    drive_d(1, 3'd0, 10'd8, 32'h0);
    check_eq("st_ack_no_rsp", 128'(bus.core_rsp_valid), 128'(0));
    check_eq("st_busy_pending", 128'(busy), 128'(1));
    step();
    clear_inputs();
    check_eq("st_ack2_no_rsp", 128'(bus.core_rsp_valid), 128'(0));
    check_eq("st_busy_idle", 128'(busy), 128'(0));

    // Outstanding cap on lane 0
    for (int k = 0; k < MAXO; k++) begin
      drive_req(0, 1'b0, 4'hF, AW'(k), 32'h0, TW'(k));
      step();
    end
    check_eq("cap_ready_low", 128'(bus.core_req_ready[0]), 128'(0));
    step();
    check_eq("cap_still_low", 128'(bus.core_req_ready[0]), 128'(0));
    clear_inputs();
    drive_d(0, 3'd0, 10'd0, 32'h0);
    step();
    clear_inputs();
    check_eq("cap_ready_back", 128'(bus.core_req_ready[0]), 128'(1));
    drive_d(0, 3'd0, 10'd0, 32'h0);
    for (int k = 0; k < MAXO - 1; k++) step();
    clear_inputs();
    check_eq("cap_busy_idle", 128'(busy), 128'(0));

    // Response FIFO full on lane 3
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      bus.core_rsp_ready = 1'b0;
      drive_req(3, 1'b0, 4'hF, AW'(32'h300 + k), 32'h0, TW'(32'h30 + k));
      if (k == 0) drive_req(0, 1'b0, 4'hF, 30'h10, 32'h0, 10'h10);
      step();
    end
    clear_inputs();
    bus.core_rsp_ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      drive_d(3, 3'd1, TW'(32'h30 + k), 32'hF000_0000 + 32'(k));
      step();
    end
    drive_d(3, 3'd1, 10'h34, 32'hF000_0004);
    drive_d(0, 3'd1, 10'h10, 32'h0000_0010);
    check_eq("full_d_ready3", 128'(bus.d_ready[3]), 128'(0));
    check_eq("full_d_ready0", 128'(bus.d_ready[0]), 128'(1));
    step();
    bus.d_valid[0] = 1'b0;
    check_eq("full_lane0_tmask", 128'(bus.core_rsp_tmask), 128'(4'b0001));
    check_eq("full_lane0_tag", 128'(bus.core_rsp_tag), 128'(10'h10));
    check_eq("full_held", 128'(bus.d_ready[3]), 128'(0));
    bus.core_rsp_ready = 1'b1;
    step();
    check_eq("full_lane3_tag0", 128'({bus.core_rsp_tmask, bus.core_rsp_tag}), 128'({4'b1000, 10'h30}));
    step();
    check_eq("full_d_ready_reopen", 128'(bus.d_ready[3]), 128'(1));
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("full_drain%0d", k), 128'({bus.core_rsp_valid, bus.core_rsp_tmask, bus.core_rsp_tag,
               bus.core_rsp_data[127:96]}), 128'({1'b1, 4'b1000, TW'(32'h30 + k), 32'hF000_0000 + 32'(k)}));
      step();
      bus.d_valid[3] = 1'b0;
    end
    check_eq("full_empty", 128'({bus.core_rsp_valid, busy}), 128'(0));

    // Perf counters: 10 single-lane fires then 3 blocked cycles
    do_reset();
    for (int k = 0; k < 10; k++) begin
      clear_inputs();
      drive_req(k % NL, 1'b0, 4'hF, AW'(k), 32'h0, TW'(k));
      step();
    end
    clear_inputs();
    bus.a_ready = '0;
    drive_req(1, 1'b0, 4'hF, 30'h77, 32'h0, 10'd1);
    for (int k = 0; k < 3; k++) step();
    clear_inputs();
    check_eq("perf_req", 128'(perf_req_count), 128'(EXP_PERF_REQ));
    check_eq("perf_stall", 128'(perf_stall_count), 128'(EXP_PERF_STALL));

    // Randomized traffic against the queue model, starting from a reset mid-operation
    do_reset();
    for (int i = 0; i < NL; i++) m_out[i] = 0;
    for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
    for (int c = 0; c < 150; c++) rand_cycle(1'b0);
    clear_inputs();
    #1;
    check_eq("rnd_final_busy", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
